// File: rtl/fp_entry_pkg.sv
// rtl/fp_entry_pkg.sv - shared types and defaults for the fp operand entry controller
package fp_entry_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        SHOW
    } state_t;

    localparam int DEFAULT_NBYTES  = 4;
    localparam int DEFAULT_TIMEOUT = 64;
    localparam int BYTE_IDX_W      = $clog2(DEFAULT_NBYTES);

endpackage

// File: rtl/fp_entry_controller_edge_detect.sv
// rtl/fp_entry_controller_edge_detect.sv - rising-edge detector for the enter level
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic press
);

    logic level_d;
    logic level_q;

    // Previous level is simply the current level delayed one cycle.
    always_comb begin
        level_d = level;
    end

    // Reset to 1 so a level already high when reset releases is not a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level_d;
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/fp_entry_controller.sv
// rtl/fp_entry_controller.sv - sequences byte-serial operand entry, launch and result display
module fp_entry_controller
    import fp_entry_pkg::*;
#(
    parameter int NBYTES         = DEFAULT_NBYTES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enter,
    input  logic                      done,
    output logic                      load_a,
    output logic                      load_b,
    output logic [$clog2(NBYTES)-1:0] byte_sel,
    output logic                      start,
    output logic                      show_result,
    output logic [$clog2(NBYTES)-1:0] result_sel,
    output logic                      busy,
    output logic                      error
);

    localparam int SEL_W = $clog2(NBYTES);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [SEL_W-1:0] SEL_MSB  = SEL_W'(NBYTES - 1);
    localparam logic [SEL_W-1:0] SEL_ZERO = '0;
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // The counter starts at 0 in the first WAIT cycle; expiry fires on the
    // update that would carry it to TIMEOUT_CYCLES-1, so an unanswered start
    // raises error TIMEOUT_CYCLES cycles after the start pulse.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic press;

    state_t           state_d,       state_q;
    logic             load_a_d,      load_a_q;
    logic             load_b_d,      load_b_q;
    logic [SEL_W-1:0] byte_sel_d,    byte_sel_q;
    logic             start_d,       start_q;
    logic             show_d,        show_q;
    logic [SEL_W-1:0] result_sel_d,  result_sel_q;
    logic             busy_d,        busy_q;
    logic             error_d,       error_q;
    logic [CNT_W-1:0] cnt_d,         cnt_q;

    edge_detect u_edge_detect (
        .clk   (clk),
        .reset (reset),
        .level (enter),
        .press (press)
    );

    // Next-state and next-output logic; every output is a flop loaded from here.
    always_comb begin
        state_d      = state_q;
        load_a_d     = 1'b0;
        load_b_d     = 1'b0;
        start_d      = 1'b0;
        byte_sel_d   = byte_sel_q;
        show_d       = show_q;
        result_sel_d = result_sel_q;
        busy_d       = busy_q;
        error_d      = error_q;
        cnt_d        = cnt_q;

        case (state_q)
            LOAD_A: begin
                // The index advances only once the strobe for it has been shown.
                if (load_a_q) begin
                    if (byte_sel_q == SEL_ZERO) begin
                        state_d    = LOAD_B;
                        byte_sel_d = SEL_MSB;
                    end else begin
                        byte_sel_d = byte_sel_q - SEL_ONE;
                    end
                end else if (press) begin
                    load_a_d = 1'b1;
                end
            end
            LOAD_B: begin
                if (load_b_q) begin
                    if (byte_sel_q == SEL_ZERO) begin
                        state_d    = START;
                        byte_sel_d = SEL_MSB;
                        start_d    = 1'b1;
                        busy_d     = 1'b1;
                        error_d    = 1'b0;
                    end else begin
                        byte_sel_d = byte_sel_q - SEL_ONE;
                    end
                end else if (press) begin
                    load_b_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
                busy_d  = 1'b1;
                cnt_d   = '0;
            end
            WAIT: begin
                // done is checked first so a done on the expiry cycle still wins.
                if (done) begin
                    state_d      = SHOW;
                    show_d       = 1'b1;
                    result_sel_d = SEL_MSB;
                    busy_d       = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = LOAD_A;
                    error_d    = 1'b1;
                    busy_d     = 1'b0;
                    byte_sel_d = SEL_MSB;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SHOW: begin
                if (press) begin
                    if (result_sel_q == SEL_ZERO) begin
                        state_d      = LOAD_A;
                        show_d       = 1'b0;
                        result_sel_d = SEL_MSB;
                    end else begin
                        result_sel_d = result_sel_q - SEL_ONE;
                    end
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // Single state/output register bank with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD_A;
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
            byte_sel_q   <= SEL_MSB;
            start_q      <= 1'b0;
            show_q       <= 1'b0;
            result_sel_q <= SEL_MSB;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            load_a_q     <= load_a_d;
            load_b_q     <= load_b_d;
            byte_sel_q   <= byte_sel_d;
            start_q      <= start_d;
            show_q       <= show_d;
            result_sel_q <= result_sel_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            cnt_q        <= cnt_d;
        end
    end

    assign load_a      = load_a_q;
    assign load_b      = load_b_q;
    assign byte_sel    = byte_sel_q;
    assign start       = start_q;
    assign show_result = show_q;
    assign result_sel  = result_sel_q;
    assign busy        = busy_q;
    assign error       = error_q;

endmodule

// File: tb/tb_fp_entry_controller.sv
// tb/tb_fp_entry_controller.sv - self-checking bench for fp_entry_controller
module tb_fp_entry_controller;

    localparam int NB = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enter = 1'b0;
    logic       done = 1'b0;
    logic       load_a, load_b, start, show_result, busy, error;
    logic [1:0] byte_sel, result_sel;

    fp_entry_controller #(
        .NBYTES         (NB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enter       (enter),
        .done        (done),
        .load_a      (load_a),
        .load_b      (load_b),
        .byte_sel    (byte_sel),
        .start       (start),
        .show_result (show_result),
        .result_sel  (result_sel),
        .busy        (busy),
        .error       (error)
    );

    typedef struct {
        int   cyc;
        int   sel;
        int   kind;
        logic err;
    } ev_t;

    localparam logic [9:0] RST_VEC = {6'b000000, 2'd3, 2'd3};

    ev_t        evq[$];
    int         rise_q[$];
    int         cyc = 0;
    int         err_rise_cyc = -1;
    logic       err_prev = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         s_cyc = 0;
    logic       m_err = 1'b0;
    logic [9:0] obs_vec;

    assign obs_vec = {load_a, load_b, start, show_result, busy, error, byte_sel, result_sel};

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Event log: strobes (kind 0 = A, 1 = B), start pulses (kind 2), error rise.
    always @(negedge clk) begin
        if (!reset) begin
            if (load_a) evq.push_back('{cyc, int'(byte_sel), 0, error});
            if (load_b) evq.push_back('{cyc, int'(byte_sel), 1, error});
            if (start)  evq.push_back('{cyc, 0, 2, error});
            if (error && !err_prev) err_rise_cyc = cyc;
        end
        err_prev = error;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enter(input int hold, input int gap);
        @(posedge clk);
        #1;
        enter = 1'b1;
        rise_q.push_back(cyc);
        repeat (hold) @(posedge clk);
        #1;
        enter = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done_at(input int c);
        while (cyc < c) step();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        enter = 1'b0;
        done  = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        m_err = 1'b0;
        err_rise_cyc = -1;
    endtask

    task automatic enter_all(input int hmin, input int hmax, input int gmax);
        evq.delete();
        rise_q.delete();
        for (int i = 0; i < 2 * NB; i++)
            pulse_enter($urandom_range(hmax, hmin), $urandom_range(gmax, 1));
        s_cyc = rise_q[2 * NB - 1] + 2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_vec !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_values: got %b want %b", obs_vec, RST_VEC);
        end
        reset = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (obs_vec !== RST_VEC) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b want %b", obs_vec, RST_VEC);
        end
    endtask

    task automatic test_entry();
        enter_all(2, 2, 3);
        n_cmp++;
        if (evq.size() != 2 * NB + 1) begin
            n_bad++;
            $display("FAIL entry_event_count: got %0d want %0d", evq.size(), 2 * NB + 1);
        end
        for (int i = 0; i < evq.size() && i < 2 * NB + 1; i++) begin
            int ek, es, ec;
            ek = (i < NB) ? 0 : (i < 2 * NB) ? 1 : 2;
            es = (i < 2 * NB) ? NB - 1 - (i % NB) : 0;
            ec = (i < 2 * NB) ? rise_q[i] + 1 : s_cyc;
            n_cmp++;
            if (evq[i].kind != ek || evq[i].sel != es || evq[i].cyc != ec) begin
                n_bad++;
                $display("FAIL entry_event_%0d: got kind %0d sel %0d cyc %0d want kind %0d sel %0d cyc %0d",
                         i, evq[i].kind, evq[i].sel, evq[i].cyc, ek, es, ec);
            end
        end
        n_cmp++;
        if (busy !== 1'b1 || start !== 1'b0) begin
            n_bad++;
            $display("FAIL entry_busy: got busy %b start %b want busy 1 start 0", busy, start);
        end
    endtask

    task automatic test_show();
        pulse_done_at(s_cyc + 5);
        n_cmp++;
        if (show_result !== 1'b1 || result_sel !== 2'(NB - 1) || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL show_enter: got show %b rsel %0d busy %b want 1 %0d 0",
                     show_result, result_sel, busy, NB - 1);
        end
        evq.delete();
        for (int p = 0; p < NB; p++) begin
            logic es;
            int   er;
            pulse_enter(2, 2);
            es = (p < NB - 1);
            er = (p < NB - 1) ? NB - 2 - p : NB - 1;
            n_cmp++;
            if (show_result !== es || result_sel !== 2'(er)) begin
                n_bad++;
                $display("FAIL show_step_%0d: got show %b rsel %0d want show %b rsel %0d",
                         p, show_result, result_sel, es, er);
            end
        end
        n_cmp++;
        if (evq.size() != 0) begin
            n_bad++;
            $display("FAIL show_no_strobes: got %0d events want 0", evq.size());
        end
    endtask

    task automatic test_hold();
        evq.delete();
        rise_q.delete();
        pulse_enter(20, 2);
        n_cmp++;
        if (evq.size() != 1 || evq[0].kind != 0 || evq[0].sel != NB - 1 || evq[0].cyc != rise_q[0] + 1) begin
            n_bad++;
            $display("FAIL hold_single_strobe: got %0d events want 1 load_a sel %0d", evq.size(), NB - 1);
        end
        n_cmp++;
        if (byte_sel !== 2'(NB - 2)) begin
            n_bad++;
            $display("FAIL hold_byte_sel: got %0d want %0d", byte_sel, NB - 2);
        end
        for (int i = 1; i < 2 * NB; i++) pulse_enter(2, 1);
        s_cyc = rise_q[2 * NB - 1] + 2;
    endtask

    task automatic test_timeout();
        err_rise_cyc = -1;
        while (cyc < s_cyc + TO + 1) step();
        n_cmp++;
        if (err_rise_cyc != s_cyc + TO) begin
            n_bad++;
            $display("FAIL timeout_cycle: got %0d want %0d", err_rise_cyc, s_cyc + TO);
        end
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || show_result !== 1'b0 || byte_sel !== 2'(NB - 1)) begin
            n_bad++;
            $display("FAIL timeout_state: got err %b busy %b show %b bsel %0d want 1 0 0 %0d",
                     error, busy, show_result, byte_sel, NB - 1);
        end
        enter_all(1, 3, 3);
        n_cmp++;
        if (evq.size() != 2 * NB + 1) begin
            n_bad++;
            $display("FAIL timeout_reentry_count: got %0d want %0d", evq.size(), 2 * NB + 1);
        end else begin
            n_cmp++;
            if (evq[2 * NB - 1].err !== 1'b1 || evq[2 * NB].kind != 2 || evq[2 * NB].err !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_error_clear: got err before start %b at start %b want 1 0",
                         evq[2 * NB - 1].err, evq[2 * NB].err);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < NB + 2; i++) pulse_enter(2, 1);
        @(posedge clk);
        #1;
        enter = 1'b1;
        step();
        n_cmp++;
        if (load_b !== 1'b1 || byte_sel !== 2'(NB - 3)) begin
            n_bad++;
            $display("FAIL rstmid_setup: got load_b %b bsel %0d want 1 %0d", load_b, byte_sel, NB - 3);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (obs_vec !== RST_VEC) begin
            n_bad++;
            $display("FAIL rstmid_async: got %b want %b", obs_vec, RST_VEC);
        end
        evq.delete();
        step();
        step();
        reset = 1'b0;
        repeat (6) step();
        n_cmp++;
        if (evq.size() != 0 || obs_vec !== RST_VEC) begin
            n_bad++;
            $display("FAIL rstmid_held_enter: got %0d events vec %b want 0 events vec %b",
                     evq.size(), obs_vec, RST_VEC);
        end
        enter = 1'b0;
        step();
        evq.delete();
        rise_q.delete();
        pulse_enter(2, 2);
        n_cmp++;
        if (evq.size() != 1 || evq[0].kind != 0 || evq[0].sel != NB - 1) begin
            n_bad++;
            $display("FAIL rstmid_first_strobe: got %0d events kind %0d want 1 load_a sel %0d",
                     evq.size(), (evq.size() > 0) ? evq[0].kind : -1, NB - 1);
        end
    endtask

    task automatic test_ignore();
        enter_all(2, 2, 1);
        evq.delete();
        pulse_enter(1, 1);
        pulse_enter(1, 1);
        n_cmp++;
        if (evq.size() != 0 || busy !== 1'b1 || show_result !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_wait_press: got %0d events busy %b show %b want 0 1 0",
                     evq.size(), busy, show_result);
        end
        pulse_done_at(s_cyc + TO - 1);
        n_cmp++;
        if (show_result !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || result_sel !== 2'(NB - 1)) begin
            n_bad++;
            $display("FAIL ignore_done_at_expiry: got show %b err %b busy %b rsel %0d want 1 0 0 %0d",
                     show_result, error, busy, result_sel, NB - 1);
        end
        repeat (3) begin
            done = 1'b1;
            step();
            done = 1'b0;
            step();
        end
        n_cmp++;
        if (show_result !== 1'b1 || result_sel !== 2'(NB - 1)) begin
            n_bad++;
            $display("FAIL ignore_done_in_show: got show %b rsel %0d want 1 %0d", show_result, result_sel, NB - 1);
        end
        for (int p = 0; p < NB; p++) pulse_enter(1, 1);
        evq.delete();
        repeat (3) begin
            done = 1'b1;
            step();
            done = 1'b0;
            step();
        end
        n_cmp++;
        if (evq.size() != 0 || show_result !== 1'b0 || byte_sel !== 2'(NB - 1) || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_done_in_load: got %0d events show %b bsel %0d busy %b want 0 0 %0d 0",
                     evq.size(), show_result, byte_sel, busy, NB - 1);
        end
        pulse_enter(1, 2);
        n_cmp++;
        if (evq.size() != 1 || evq[0].kind != 0 || evq[0].sel != NB - 1) begin
            n_bad++;
            $display("FAIL ignore_still_load_a: got %0d events want 1 load_a sel %0d", evq.size(), NB - 1);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            logic to;
            to = ($urandom_range(2, 0) == 0);
            err_rise_cyc = -1;
            enter_all(1, 4, 3);
            n_cmp++;
            if (evq.size() != 2 * NB + 1) begin
                n_bad++;
                $display("FAIL b2b_%0d_count: got %0d want %0d", r, evq.size(), 2 * NB + 1);
            end
            for (int i = 0; i < evq.size() && i < 2 * NB + 1; i++) begin
                int   ek, es, ec;
                logic ee;
                ek = (i < NB) ? 0 : (i < 2 * NB) ? 1 : 2;
                es = (i < 2 * NB) ? NB - 1 - (i % NB) : 0;
                ec = (i < 2 * NB) ? rise_q[i] + 1 : s_cyc;
                ee = (i < 2 * NB) ? m_err : 1'b0;
                n_cmp++;
                if (evq[i].kind != ek || evq[i].sel != es || evq[i].cyc != ec || evq[i].err !== ee) begin
                    n_bad++;
                    $display("FAIL b2b_%0d_event_%0d: got k%0d s%0d c%0d e%b want k%0d s%0d c%0d e%b",
                             r, i, evq[i].kind, evq[i].sel, evq[i].cyc, evq[i].err, ek, es, ec, ee);
                end
            end
            if (to) begin
                while (cyc < s_cyc + TO + 1) step();
                n_cmp++;
                if (err_rise_cyc != s_cyc + TO || error !== 1'b1 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_%0d_timeout: got rise %0d err %b busy %b want %0d 1 0",
                             r, err_rise_cyc, error, busy, s_cyc + TO);
                end
                m_err = 1'b1;
            end else begin
                int d;
                d = $urandom_range(TO - 1, 6);
                pulse_done_at(s_cyc + d);
                n_cmp++;
                if (show_result !== 1'b1 || result_sel !== 2'(NB - 1) || error !== 1'b0 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_%0d_show: got show %b rsel %0d err %b busy %b want 1 %0d 0 0",
                             r, show_result, result_sel, error, busy, NB - 1);
                end
                m_err = 1'b0;
                for (int p = 0; p < NB; p++) begin
                    logic es2;
                    int   er;
                    pulse_enter($urandom_range(4, 1), $urandom_range(3, 1));
                    es2 = (p < NB - 1);
                    er  = (p < NB - 1) ? NB - 2 - p : NB - 1;
                    n_cmp++;
                    if (show_result !== es2 || result_sel !== 2'(er)) begin
                        n_bad++;
                        $display("FAIL b2b_%0d_rsel_%0d: got show %b rsel %0d want %b %0d",
                                 r, p, show_result, result_sel, es2, er);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_show();
        test_hold();
        test_timeout();
        test_reset_mid();
        apply_reset();
        test_ignore();
        apply_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
